// File: rtl/ram_arbiter.sv
// Two-requester arbiter (fetch, memory stage) onto a 16-bit RAM port; each 32-bit word moves as HI then LO beats.
// Latency 2*WAIT_CYCLES+1 from grant to ack; requests wait via *_stall while another transaction is in flight.
module ram_arbiter #(
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [17:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_stall,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [17:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        mem_stall,
    output logic [17:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        ram_wre,
    output logic        ram_en
);

    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_ACK} state_t;

    localparam logic [3:0] BEAT_LAST = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_starve;
    logic        r_owner_mem;
    logic        r_we;
    logic [17:0] r_base;
    logic [15:0] r_wdata_lo;
    logic [31:0] r_if_rdata;
    logic [31:0] r_mem_rdata;
    logic        r_if_ack;
    logic        r_mem_ack;
    logic [17:0] r_ram_addr;
    logic [15:0] r_ram_wdata;
    logic        r_ram_wre;
    logic        r_ram_en;

    logic        w_grant_if;
    logic        w_grant_mem;
    logic        w_grant_wr;
    logic        w_beat_last;
    logic [17:0] w_base;
    logic        w_unused_addr_lsb;

    // Fetch pre-empts mem only once it has watched STARVE_LIMIT mem grants go by.
    assign w_grant_if  = if_req & (~mem_req | (r_starve == STARVE_MAX));
    assign w_grant_mem = mem_req & ~w_grant_if;
    assign w_grant_wr  = w_grant_mem & mem_we;
    assign w_beat_last = (r_cnt == BEAT_LAST);
    assign w_base      = w_grant_mem ? {1'b0, mem_addr[17:1]} : {1'b0, if_addr[17:1]};
    assign w_unused_addr_lsb = if_addr[0] ^ mem_addr[0];

    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign if_ack    = r_if_ack;
    assign mem_ack   = r_mem_ack;
    assign if_stall  = if_req & ~r_if_ack;
    assign mem_stall = mem_req & ~r_mem_ack;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_wre   = r_ram_wre;
    assign ram_en    = r_ram_en;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_starve    <= 4'd0;
            r_owner_mem <= 1'b0;
            r_we        <= 1'b0;
            r_base      <= 18'd0;
            r_wdata_lo  <= 16'd0;
            r_if_rdata  <= 32'd0;
            r_mem_rdata <= 32'd0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_ram_addr  <= 18'd0;
            r_ram_wdata <= 16'd0;
            r_ram_wre   <= 1'b1;
            r_ram_en    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!if_req || w_grant_if) begin
                        r_starve <= 4'd0;
                    end else if (w_grant_mem && r_starve != STARVE_MAX) begin
                        r_starve <= r_starve + 4'd1;
                    end
                    if (w_grant_if || w_grant_mem) begin
                        r_state     <= S_HI;
                        r_cnt       <= 4'd0;
                        r_owner_mem <= w_grant_mem;
                        r_we        <= w_grant_wr;
                        r_base      <= w_base;
                        r_wdata_lo  <= w_grant_wr ? mem_wdata[15:0] : 16'd0;
                        r_ram_addr  <= w_base;
                        r_ram_wdata <= w_grant_wr ? mem_wdata[31:16] : 16'd0;
                        r_ram_wre   <= ~w_grant_wr;
                        r_ram_en    <= 1'b1;
                    end
                end
                S_HI: begin
                    if (w_beat_last) begin
                        if (!r_we) begin
                            if (r_owner_mem) r_mem_rdata[31:16] <= ram_rdata;
                            else             r_if_rdata[31:16]  <= ram_rdata;
                        end
                        r_state     <= S_LO;
                        r_cnt       <= 4'd0;
                        r_ram_addr  <= r_base + 18'd1;
                        r_ram_wdata <= r_wdata_lo;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_LO: begin
                    if (w_beat_last) begin
                        if (!r_we) begin
                            if (r_owner_mem) r_mem_rdata[15:0] <= ram_rdata;
                            else             r_if_rdata[15:0]  <= ram_rdata;
                        end
                        r_state   <= S_ACK;
                        r_cnt     <= 4'd0;
                        r_ram_en  <= 1'b0;
                        r_ram_wre <= 1'b1;
                        r_mem_ack <= r_owner_mem;
                        r_if_ack  <= ~r_owner_mem;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_ACK: begin
                    r_if_ack  <= 1'b0;
                    r_mem_ack <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: W=1/STARVE_LIMIT=2 instance with a RAM model, plus a W=3 instance with hand-driven RAM data.
module tb_ram_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    always #5 clock = ~clock;

    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [17:0] if_addr = 18'd0, mem_addr = 18'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] if_rdata, mem_rdata;
    logic        if_ack, if_stall, mem_ack, mem_stall;
    logic [17:0] ram_addr;
    logic [15:0] ram_wdata, ram_rdata;
    logic        ram_wre, ram_en;
    logic [15:0] ram0 [0:1023];

    logic        if_req_b = 1'b0;
    logic [17:0] if_addr_b = 18'd0;
    logic [31:0] if_rdata_b, mem_rdata_b;
    logic        if_ack_b, if_stall_b, mem_ack_b, mem_stall_b;
    logic [17:0] ram_addr_b;
    logic [15:0] ram_wdata_b;
    logic [15:0] ram_rdata_b = 16'd0;
    logic        ram_wre_b, ram_en_b;

    int total = 0;
    int bad = 0;

    ram_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(2)) u0 (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_wre(ram_wre), .ram_en(ram_en)
    );

    ram_arbiter #(.WAIT_CYCLES(3), .STARVE_LIMIT(4)) u1 (
        .clock(clock), .reset(reset),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_rdata(if_rdata_b), .if_ack(if_ack_b), .if_stall(if_stall_b),
        .mem_req(1'b0), .mem_we(1'b0), .mem_addr(18'd0), .mem_wdata(32'd0),
        .mem_rdata(mem_rdata_b), .mem_ack(mem_ack_b), .mem_stall(mem_stall_b),
        .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b),
        .ram_wre(ram_wre_b), .ram_en(ram_en_b)
    );

    assign ram_rdata = ram0[ram_addr[9:0]];
    always @(posedge clock) begin
        if (ram_en && !ram_wre) ram0[ram_addr[9:0]] <= ram_wdata;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    initial begin
        logic order [6];
        logic exp_order [6];
        int   n;
        int   gap;
        for (int i = 0; i < 1024; i++) ram0[i] = 16'h0000;
        ram0[10'h010] = 16'h1234;
        ram0[10'h011] = 16'hABCD;
        ram0[10'h3FF] = 16'h0F0F;
        ram0[10'h000] = 16'hF0F0;
        exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset state
        tick();
        chk("rst_wre", ram_wre, 1);
        chk("rst_en", ram_en, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_acks", {if_ack, mem_ack}, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        reset = 1'b1;
        tick();

        // Fetch read at byte 0x20
        if_req = 1'b1; if_addr = 18'h00020;
        tick();
        chk("f_hi_addr", ram_addr, 18'h00010);
        chk("f_hi_en_wre", {ram_en, ram_wre}, 2'b11);
        chk("f_hi_stall", if_stall, 1);
        tick();
        chk("f_lo_addr", ram_addr, 18'h00011);
        chk("f_lo_ack", if_ack, 0);
        tick();
        chk("f_ack", if_ack, 1);
        chk("f_stall_ack", if_stall, 0);
        chk("f_rdata", if_rdata, 32'h1234ABCD);
        chk("f_mem_rdata", mem_rdata, 0);
        chk("f_ack_en", ram_en, 0);
        if_req = 1'b0;
        tick();
        chk("f_ack_pulse", if_ack, 0);

        // Mem write 0xDEADBEEF to 0x100
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00100; mem_wdata = 32'hDEADBEEF;
        tick();
        chk("w_hi", {ram_addr, ram_wdata, ram_wre, ram_en}, {18'h00080, 16'hDEAD, 1'b0, 1'b1});
        tick();
        chk("w_lo", {ram_addr, ram_wdata, ram_wre, ram_en}, {18'h00081, 16'hBEEF, 1'b0, 1'b1});
        tick();
        chk("w_ack", {mem_ack, if_ack, ram_wre}, 3'b101);
        chk("w_mem_rdata", mem_rdata, 0);
        mem_req = 1'b0; mem_we = 1'b0;
        tick();

        // Mem read back
        mem_req = 1'b1;
        tick(); tick(); tick();
        chk("r_ack", mem_ack, 1);
        chk("r_rdata", mem_rdata, 32'hDEADBEEF);
        chk("r_if_rdata", if_rdata, 32'h1234ABCD);
        mem_req = 1'b0;
        tick();

        // Odd byte address: lsb ignored
        if_req = 1'b1; if_addr = 18'h3FFFF;
        tick();
        chk("odd_hi_addr", ram_addr, 18'h1FFFF);
        tick();
        chk("odd_lo_addr", ram_addr, 18'h20000);
        tick();
        chk("odd_rdata", if_rdata, 32'h0F0FF0F0);
        if_req = 1'b0;
        tick();

        // Simultaneous requests: mem first, fetch ack 2W+2 after mem ack
        if_req = 1'b1; if_addr = 18'h00020;
        mem_req = 1'b1; mem_addr = 18'h00100;
        tick();
        chk("pri_hi_addr", ram_addr, 18'h00080);
        tick(); tick();
        chk("pri_mem_ack", {mem_ack, if_ack}, 2'b10);
        mem_req = 1'b0;
        gap = 0;
        n = 0;
        while (n < 20 && !if_ack) begin
            tick();
            gap++;
            n++;
        end
        chk("pri_if_gap", gap, 4);
        chk("pri_if_rdata", if_rdata, 32'h1234ABCD);
        if_req = 1'b0;
        tick();

        // Starvation with both requests held high
        if_req = 1'b1; mem_req = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            tick();
            if (mem_ack) begin order[n] = 1'b1; n++; end
            else if (if_ack) begin order[n] = 1'b0; n++; end
        end
        chk("stv_count", n, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("stv_grant%0d", i), order[i], exp_order[i]);
        if_req = 1'b0; mem_req = 1'b0;
        tick(); tick();

        // Reset mid-LO
        if_req = 1'b1;
        tick(); tick();
        chk("mr_lo_addr", ram_addr, 18'h00011);
        #2 reset = 1'b0;
        #1;
        chk("mr_wre_en", {ram_wre, ram_en}, 2'b10);
        chk("mr_acks", {if_ack, mem_ack}, 0);
        chk("mr_rdata", {if_rdata, mem_rdata}, 64'd0);
        tick();
        chk("mr_hold", {ram_wre, ram_en, if_ack}, 3'b100);
        reset = 1'b1;
        tick();
        chk("mr_regrant", {ram_addr, ram_en}, {18'h00010, 1'b1});
        tick(); tick();
        chk("mr_ack", if_ack, 1);
        chk("mr_rdata2", if_rdata, 32'h1234ABCD);
        if_req = 1'b0;
        tick();

        // W=3 single fetch read; RAM data changes every cycle
        if_req_b = 1'b1; if_addr_b = 18'h00020;
        tick();
        chk("w3_hi1", ram_addr_b, 18'h00010);
        ram_rdata_b = 16'h1111;
        tick();
        chk("w3_hi2", ram_addr_b, 18'h00010);
        ram_rdata_b = 16'h2222;
        tick();
        chk("w3_hi3", {ram_addr_b, ram_en_b}, {18'h00010, 1'b1});
        ram_rdata_b = 16'h3333;
        tick();
        chk("w3_lo1", ram_addr_b, 18'h00011);
        chk("w3_hi_cap", if_rdata_b[31:16], 16'h3333);
        ram_rdata_b = 16'h4444;
        tick();
        chk("w3_lo2", ram_addr_b, 18'h00011);
        ram_rdata_b = 16'h5555;
        tick();
        chk("w3_lo3", {ram_addr_b, if_ack_b}, {18'h00011, 1'b0});
        ram_rdata_b = 16'h6666;
        tick();
        chk("w3_ack", {if_ack_b, ram_en_b}, 2'b10);
        chk("w3_rdata", if_rdata_b, 32'h33336666);
        if_req_b = 1'b0;
        tick();
        chk("w3_ack_pulse", if_ack_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
